// File: rtl/ahb_core_master_pkg.sv
// ahb_core_master_pkg
// Shared types and constants for the core-side AHB-Lite initiator:
// transfer types, transfer sizes, FSM state codes, protection encodings,
// the default ROM/RAM address map and the store-data lane replicator.
package ahb_core_master_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    localparam logic [3:0] HPROT_FETCH = 4'b0010;
    localparam logic [3:0] HPROT_DATA  = 4'b0011;

    localparam logic [31:0] DEF_ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_ROM_MASK = 32'hFFFF_0000;
    localparam logic [31:0] DEF_RAM_BASE = 32'h1000_0000;
    localparam logic [31:0] DEF_RAM_MASK = 32'hFFFF_0000;

    // Store data arrives LSB-justified; AHB slaves pick their own lanes,
    // so narrow stores are replicated across the whole word.
    function automatic logic [31:0] lane_replicate(input logic [2:0] size,
                                                   input logic [31:0] data);
        case (size)
            HSIZE_BYTE: return {4{data[7:0]}};
            HSIZE_HALF: return {2{data[15:0]}};
            default:    return data;
        endcase
    endfunction

endpackage

// File: rtl/ahb_core_master_if.sv
// ahb_core_master_if
// AHB-Lite signals between the initiator and the instruction-ROM /
// data-RAM slave pair.
//   master modport: drives selects, address/control and write data;
//                   receives both slaves' read data, hready and hresp.
//   slave modport : the mirror image, for slave models.
interface ahb_core_master_if;
    logic        HSEL1;
    logic        HSEL2;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        is_signed;
    logic [31:0] hwdata;
    logic [31:0] instruction;
    logic [31:0] load_out;
    logic        hready_inst;
    logic        hready_data;
    logic        hresp_inst;
    logic        hresp_data;

    modport master (
        output HSEL1, HSEL2, haddr, hwrite, hsize, hprot, htrans, is_signed, hwdata,
        input  instruction, load_out, hready_inst, hready_data, hresp_inst, hresp_data
    );

    modport slave (
        input  HSEL1, HSEL2, haddr, hwrite, hsize, hprot, htrans, is_signed, hwdata,
        output instruction, load_out, hready_inst, hready_data, hresp_inst, hresp_data
    );
endinterface

// File: rtl/ahb_load_align.sv
// ahb_load_align
// Combinational load-data lane extraction and extension.
//   word      in  32  raw read word from the slave
//   addr      in  2   byte offset of the access
//   size      in  3   0 byte, 1 half, 2 word
//   is_signed in  1   sign-extend when 1, zero-extend when 0
//   result    out 32  aligned, extended load value
module ahb_load_align
    import ahb_core_master_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{addr, 3'b000} +: 8];
        lane_h = word[{addr[1], 4'b0000} +: 16];
        case (size)
            HSIZE_BYTE: result = {{24{is_signed & lane_b[7]}}, lane_b};
            HSIZE_HALF: result = {{16{is_signed & lane_h[15]}}, lane_h};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/ahb_core_master.sv
// ahb_core_master
// AHB-Lite initiator for the multicycle core's fetch/load-store port.
// One request at a time: decode ROM/RAM target, check alignment, run the
// address and data phases, return an aligned/extended result.
//   clk, reset         system clock, synchronous active-low reset
//   req_valid/ready    core request handshake (ready only in IDLE)
//   req_fetch/write    fetch vs data access, store flag
//   req_addr/wdata     byte address, LSB-justified store data
//   req_size/signed    access size and load extension
//   resp_valid/rdata/err  one-cycle response pulse
//   bus                AHB-Lite master side (ROM on HSEL1, RAM on HSEL2)
module ahb_core_master
    import ahb_core_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [31:0] ROM_MASK = DEF_ROM_MASK,
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [31:0] RAM_MASK = DEF_RAM_MASK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_fetch,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    ahb_core_master_if.master bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t             state;
    logic               lat_fetch;
    logic               lat_write;
    logic [1:0]         lat_offs;
    logic [2:0]         lat_size;
    logic               lat_signed;
    logic [31:0]        lat_wdata;
    logic [CNT_W-1:0]   wait_cnt;
    logic               err_sticky;

    logic               rom_hit;
    logic               ram_hit;
    logic               map_ok;
    logic               align_ok;
    logic               sel_ready;
    logic               sel_resp;
    logic [31:0]        sel_word;
    logic [31:0]        load_word;
    logic [31:0]        final_word;
    logic               err_now;

    assign req_ready = (state == ST_IDLE);

    always_comb begin
        rom_hit = (req_addr & ROM_MASK) == ROM_BASE;
        ram_hit = (req_addr & RAM_MASK) == RAM_BASE;
        if (req_fetch) begin
            map_ok = rom_hit;
        end else begin
            map_ok = ram_hit && !(req_write && rom_hit);
        end
        case (req_size)
            HSIZE_BYTE: align_ok = 1'b1;
            HSIZE_HALF: align_ok = !req_addr[0];
            HSIZE_WORD: align_ok = (req_addr[1:0] == 2'b00);
            default:    align_ok = 1'b0;
        endcase
    end

    // Fetches always target the ROM and data accesses the RAM, so the
    // latched fetch flag doubles as the slave select for the data phase.
    always_comb begin
        sel_ready  = lat_fetch ? bus.hready_inst : bus.hready_data;
        sel_resp   = lat_fetch ? bus.hresp_inst  : bus.hresp_data;
        sel_word   = lat_fetch ? bus.instruction : bus.load_out;
        final_word = lat_fetch ? sel_word : load_word;
        err_now    = err_sticky | sel_resp;
    end

    ahb_load_align u_align (
        .word      (sel_word),
        .addr      (lat_offs),
        .size      (lat_size),
        .is_signed (lat_signed),
        .result    (load_word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            lat_fetch     <= 1'b0;
            lat_write     <= 1'b0;
            lat_offs      <= '0;
            lat_size      <= '0;
            lat_signed    <= 1'b0;
            lat_wdata     <= '0;
            wait_cnt      <= '0;
            err_sticky    <= 1'b0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            bus.HSEL1     <= 1'b0;
            bus.HSEL2     <= 1'b0;
            bus.haddr     <= '0;
            bus.hwrite    <= 1'b0;
            bus.hsize     <= '0;
            bus.hprot     <= '0;
            bus.htrans    <= HTRANS_IDLE;
            bus.is_signed <= 1'b0;
            bus.hwdata    <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_fetch  <= req_fetch;
                        lat_write  <= req_write & ~req_fetch;
                        lat_offs   <= req_addr[1:0];
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_wdata  <= req_wdata;
                        if (map_ok && align_ok) begin
                            state         <= ST_ADDR;
                            bus.htrans    <= HTRANS_NONSEQ;
                            bus.HSEL1     <= req_fetch;
                            bus.HSEL2     <= ~req_fetch;
                            bus.haddr     <= req_addr;
                            bus.hwrite    <= req_write & ~req_fetch;
                            bus.hsize     <= req_size;
                            bus.hprot     <= req_fetch ? HPROT_FETCH : HPROT_DATA;
                            bus.is_signed <= req_signed;
                        end else begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    state         <= ST_DATA;
                    bus.htrans    <= HTRANS_IDLE;
                    bus.HSEL1     <= 1'b0;
                    bus.HSEL2     <= 1'b0;
                    bus.haddr     <= '0;
                    bus.hwrite    <= 1'b0;
                    bus.hsize     <= '0;
                    bus.hprot     <= '0;
                    bus.is_signed <= 1'b0;
                    bus.hwdata    <= lat_write ? lane_replicate(lat_size, lat_wdata) : '0;
                    wait_cnt      <= '0;
                    err_sticky    <= 1'b0;
                end
                ST_DATA: begin
                    if (sel_resp) begin
                        err_sticky <= 1'b1;
                    end
                    // hready wins over the timeout so a slave answering on
                    // the last permitted cycle still completes normally.
                    if (sel_ready) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err_now;
                        resp_rdata <= (err_now || lat_write) ? '0 : final_word;
                        bus.hwdata <= '0;
                    end else if (wait_cnt == CNT_MAX) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        bus.hwdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_core_master.sv
// tb_ahb_core_master
// Self-checking bench: directed and random requests against a reference
// model of the address map, alignment, latency and load-extension rules.
module tb_ahb_core_master;

    localparam int unsigned T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_fetch;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_assert = 0;
    int n_fail   = 0;

    ahb_core_master_if bus ();

    ahb_core_master #(
        .TIMEOUT_CYCLES (T),
        .ROM_BASE       (32'h0000_0000),
        .ROM_MASK       (32'hFFFF_0000),
        .RAM_BASE       (32'h1000_0000),
        .RAM_MASK       (32'hFFFF_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fetch  (req_fetch),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_signed (req_signed),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Reference: address map, alignment and latency rules plus lane
    // extraction, computed with plain arithmetic on the byte address.
    function automatic void model(input bit fetch, input bit write, input logic [31:0] addr,
                                  input logic [2:0] size, input bit sgn, input logic [31:0] word,
                                  input int unsigned waits, input bit hresp_hit,
                                  output bit bus_used, output bit err,
                                  output logic [31:0] rdata, output int unsigned edges);
        bit in_rom;
        bit in_ram;
        bit store;
        bit bad_map;
        bit bad_align;
        int unsigned v;
        in_rom    = (addr & 32'hFFFF_0000) == 32'h0000_0000;
        in_ram    = (addr & 32'hFFFF_0000) == 32'h1000_0000;
        store     = write && !fetch;
        bad_map   = fetch ? !in_rom : (!in_ram || (store && in_rom));
        bad_align = (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0) || size > 2;
        if (bad_map || bad_align) begin
            bus_used = 0; err = 1; rdata = 0; edges = 0;
            return;
        end
        bus_used = 1;
        if (waits > T) begin
            err = 1; rdata = 0; edges = T + 2;
            return;
        end
        edges = 2 + waits;
        err   = hresp_hit;
        if (err || store) begin
            rdata = 0;
        end else if (fetch || size == 2) begin
            rdata = word;
        end else if (size == 0) begin
            v = (word >> (8 * (addr % 4))) % 256;
            if (sgn && v >= 128) v = v - 256;
            rdata = v;
        end else begin
            v = (word >> (16 * ((addr / 2) % 2))) % 65536;
            if (sgn && v >= 32768) v = v - 65536;
            rdata = v;
        end
    endfunction

    task automatic idle_slaves();
        bus.hready_inst = 0; bus.hresp_inst = 0; bus.instruction = '0;
        bus.hready_data = 0; bus.hresp_data = 0; bus.load_out    = '0;
    endtask

    task automatic run_txn(input string name, input bit fetch, input bit write,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size, input bit sgn, input logic [31:0] word,
                           input int unsigned waits, input bit err_mid, input bit err_final);
        bit          bus_used;
        bit          e_err;
        logic [31:0] e_rdata;
        int unsigned e_edges;
        int unsigned edges;
        bit          done;
        bit          store;
        bit          hresp_hit;
        bit          sel_rdy;
        bit          sel_rsp;
        logic [31:0] e_hwdata;
        store     = write && !fetch;
        hresp_hit = (err_mid && waits > 0) || err_final;
        model(fetch, write, addr, size, sgn, word, waits, hresp_hit, bus_used, e_err, e_rdata, e_edges);
        if (size == 0)      e_hwdata = (wdata % 256) * 32'h0101_0101;
        else if (size == 1) e_hwdata = (wdata % 65536) * 32'h0001_0001;
        else                e_hwdata = wdata;

        @(negedge clk);
        req_valid = 1; req_fetch = fetch; req_write = write; req_addr = addr;
        req_wdata = wdata; req_size = size; req_signed = sgn;
        check({name, ":req_ready_idle"}, req_ready, 1);
        @(posedge clk); #1;
        // a different request held on the port while busy must be ignored
        req_addr = $urandom; req_wdata = $urandom; req_fetch = 1'($urandom);
        req_write = 1'($urandom); req_size = 3'($urandom); req_signed = 1'($urandom);
        edges = 0;
        done  = 0;
        if (!bus_used) begin
            check({name, ":decode_resp_valid"}, resp_valid, 1);
            check({name, ":decode_sel"}, {bus.HSEL1, bus.HSEL2}, 0);
            check({name, ":decode_htrans"}, bus.htrans, 0);
            done = resp_valid;
        end else begin
            check({name, ":addr_htrans"}, bus.htrans, 2);
            check({name, ":addr_sel"}, {bus.HSEL1, bus.HSEL2}, {fetch, !fetch});
            check({name, ":addr_haddr"}, bus.haddr, addr);
            check({name, ":addr_ctrl"}, {bus.hwrite, bus.hsize, bus.hprot, bus.is_signed},
                  {store, size, (fetch ? 4'b0010 : 4'b0011), sgn});
            check({name, ":addr_req_ready"}, req_ready, 0);
            idle_slaves();
            @(posedge clk); #1;
            edges = 1;
            for (int unsigned k = 0; k < T + 8 && !done; k++) begin
                if (k == 0) begin
                    check({name, ":data_idle"}, {bus.htrans, bus.HSEL1, bus.HSEL2}, 0);
                    if (store) check({name, ":hwdata"}, bus.hwdata, e_hwdata);
                end
                sel_rdy = (k >= waits);
                sel_rsp = (err_mid && k == 0 && waits > 0) || (err_final && k >= waits);
                if (fetch) begin
                    bus.hready_inst = sel_rdy; bus.hresp_inst = sel_rsp; bus.instruction = word;
                    bus.hready_data = !sel_rdy; bus.hresp_data = 1; bus.load_out = ~word;
                end else begin
                    bus.hready_data = sel_rdy; bus.hresp_data = sel_rsp; bus.load_out = word;
                    bus.hready_inst = !sel_rdy; bus.hresp_inst = 1; bus.instruction = ~word;
                end
                @(posedge clk); #1;
                edges++;
                if (resp_valid) done = 1;
            end
            check({name, ":resp_seen"}, done, 1);
        end
        req_valid = 0;
        check({name, ":latency"}, edges, e_edges);
        check({name, ":resp_err"}, resp_err, e_err);
        check({name, ":resp_rdata"}, resp_rdata, e_rdata);
        idle_slaves();
        @(posedge clk); #1;
        check({name, ":resp_pulse_end"}, {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned sc;
        int unsigned region;
        int unsigned waits;
        bit          f;
        bit          w;
        bit          saw_resp;
        logic [2:0]  sz;
        logic [31:0] a;

        reset = 0; req_valid = 0; req_fetch = 0; req_write = 0; req_addr = '0;
        req_wdata = '0; req_size = '0; req_signed = 0;
        idle_slaves();
        repeat (2) @(posedge clk);
        #1;
        check("reset_core_side", {req_ready, resp_valid, resp_err, resp_rdata}, {3'b100, 32'h0});
        check("reset_bus_ctrl", {bus.htrans, bus.HSEL1, bus.HSEL2, bus.hwrite, bus.hsize,
                                 bus.hprot, bus.is_signed}, 0);
        check("reset_haddr", bus.haddr, 0);
        check("reset_hwdata", bus.hwdata, 0);
        @(negedge clk);
        reset = 1;

        run_txn("fetch_rom",      1, 0, 32'h0000_0010, 32'h0,         3'd2, 0, 32'hDEAD_BEEF, 0, 0, 0);
        run_txn("ld_sbyte",       0, 0, 32'h1000_0003, 32'h0,         3'd0, 1, 32'h8011_2233, 0, 0, 0);
        run_txn("ld_uhalf",       0, 0, 32'h1000_0002, 32'h0,         3'd1, 0, 32'h8011_2233, 1, 0, 0);
        run_txn("ld_shalf",       0, 0, 32'h1000_0000, 32'h0,         3'd1, 1, 32'h1234_9ABC, 0, 0, 0);
        run_txn("st_byte",        0, 1, 32'h1000_0001, 32'h1234_56A5, 3'd0, 0, 32'h0,         0, 0, 0);
        run_txn("st_half",        0, 1, 32'h1000_0006, 32'hFFFF_BEEF, 3'd1, 0, 32'h0,         2, 0, 0);
        run_txn("ld_misaligned",  0, 0, 32'h1000_0002, 32'h0,         3'd2, 0, 32'h0,         0, 0, 0);
        run_txn("st_rom",         0, 1, 32'h0000_0000, 32'h55,        3'd2, 0, 32'h0,         0, 0, 0);
        run_txn("fetch_ram",      1, 0, 32'h1000_0000, 32'h0,         3'd2, 0, 32'h0,         0, 0, 0);
        run_txn("timeout_20",     0, 0, 32'h1000_0100, 32'h0,         3'd2, 0, 32'h1111_2222, 20, 0, 0);
        run_txn("wait_16_ok",     0, 0, 32'h1000_0104, 32'h0,         3'd2, 0, 32'h3333_4444, 16, 0, 0);
        run_txn("wait_17_tmo",    0, 0, 32'h1000_0108, 32'h0,         3'd2, 0, 32'h5555_6666, 17, 0, 0);
        run_txn("hresp_sticky",   0, 0, 32'h1000_0010, 32'h0,         3'd2, 0, 32'h7777_8888, 3, 1, 0);
        run_txn("hresp_with_rdy", 1, 0, 32'h0000_0020, 32'h0,         3'd2, 0, 32'h9999_AAAA, 0, 0, 1);

        // reset during the data phase aborts without a response
        @(negedge clk);
        req_valid = 1; req_fetch = 0; req_write = 0; req_addr = 32'h1000_0008;
        req_size = 3'd2; req_signed = 0;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        check("midreset_bus", {bus.htrans, bus.HSEL1, bus.HSEL2, bus.hwrite}, 0);
        check("midreset_core", {resp_valid, resp_err, req_ready}, 3'b001);
        reset = 1;
        saw_resp = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1;
        end
        check("midreset_no_resp", saw_resp, 0);
        run_txn("after_reset", 0, 0, 32'h1000_0008, 32'h0, 3'd0, 1, 32'h00F0_0000, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            region = $urandom_range(0, 9);
            if (region < 4)      a = 32'h0000_0000 | $urandom_range(0, 65535);
            else if (region < 9) a = 32'h1000_0000 | $urandom_range(0, 65535);
            else                 a = 32'h2000_0000 | $urandom_range(0, 65535);
            f  = (region < 4) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0 && sz <= 2) a = a & ~((32'd1 << sz) - 1);
            waits = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(0, 3);
            sc = $urandom_range(0, 7);
            run_txn("rand", f, w, a, $urandom, sz, 1'($urandom_range(0, 1)), $urandom,
                    waits, sc == 0, sc == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_core_master.md
# ahb_core_master

AHB-Lite initiator between the multicycle core's fetch/load-store request port and the instruction-ROM / data-RAM slave pair. Accepts one request at a time from the core. Decodes the target slave, checks alignment, and runs the AHB address and data phases. Returns byte-lane-aligned, sign/zero-extended load data or a fetch word, with error and timeout reporting.

## Interface
- TIMEOUT_CYCLES, 16: maximum data-phase wait cycles before a forced error response
- ROM_BASE, 32'h0000_0000: instruction-ROM base; ROM_MASK, 32'hFFFF_0000: ROM decode mask
- RAM_BASE, 32'h1000_0000: data-RAM base; RAM_MASK, 32'hFFFF_0000: RAM decode mask
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  high in IDLE only
- req_fetch  in  1  1 = instruction fetch, 0 = data access
- req_write  in  1  store when 1 (ignored if req_fetch)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- req_size  in  3  0 byte, 1 half, 2 word
- req_signed  in  1  sign-extend load
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  fetch word or extended load data
- resp_err  out  1  qualifies resp_valid
- HSEL1, HSEL2  out  1  ROM / RAM select
- haddr  out  32; hwrite  out  1; hsize  out  3; hprot  out  4; htrans  out  2; is_signed  out  1
- hwdata  out  32  lane-replicated store data
- instruction, load_out  in  32  ROM / RAM read data
- hready_inst, hready_data, hresp_inst, hresp_data  in  1  slave handshakes

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE
  - req_ready=1.
  - On req_valid, latch the request.
  - Decode: ROM hit if (addr & ROM_MASK)==ROM_BASE; RAM hit likewise.
  - Fetch must hit ROM. A data access must hit RAM. A write to ROM is an error.
  - Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
  - Decode or alignment failure → RESP with err=1, no bus activity. Otherwise → ADDR.
- ADDR (one cycle)
  - htrans=NONSEQ (2'b10); HSEL1 or HSEL2 high.
  - Drive haddr, hwrite, hsize, is_signed.
  - hprot=4'b0010 for a fetch, 4'b0011 for data.
  - → DATA.
- DATA
  - htrans=IDLE; selects and control deasserted.
  - hwdata driven for stores: byte replicated ×4, half ×2, word as-is.
  - Selected slave's hresp=1 on any cycle sets a sticky err.
  - On selected hready=1: capture read data, → RESP.
  - The wait counter increments each cycle hready=0. At TIMEOUT_CYCLES: err=1, → RESP.
- RESP (one cycle)
  - resp_valid=1 with resp_err/resp_rdata. → IDLE.
  - Stores and errors return resp_rdata=0.
- Load alignment:
  - byte = word[8*addr[1:0] +: 8]; half = word[16*addr[1] +: 16].
  - Extend to 32 bits per req_signed. Word passes through.
  - Fetch data is never extended.

## Timing
- Reset (sampled low at clk edge): state IDLE.
  - Outputs: req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0.
  - Bus: htrans=2'b00; HSEL1=HSEL2=0; haddr=0, hwdata=0; hwrite=0, hsize=0, hprot=0, is_signed=0.
  - Wait counter=0.
- A reset asserted mid-transaction aborts the transaction. No resp_valid is issued for it.
- Minimum latency, accept edge to resp_valid: 3 cycles (ADDR, DATA with hready=1, RESP).
- Error from decode: resp_valid 1 cycle after accept.
- Each extra hready=0 cycle adds one cycle of latency. Timeout response arrives TIMEOUT_CYCLES+2 cycles after ADDR.
- req_valid during ADDR/DATA/RESP is not accepted; the core must hold the request.
- hresp=1 together with hready=1 in the same cycle → error, finishes immediately.
- Only the selected slave's hready/hresp is observed; the other slave's handshakes are ignored.

## Structure
- Package ahb_core_master_pkg holds:
  - htrans_t (IDLE/BUSY/NONSEQ/SEQ)
  - hsize constants (BYTE/HALF/WORD)
  - state_t
  - HPROT_FETCH / HPROT_DATA constants
  - default map bases and masks
- Sub-module ahb_load_align: combinational lane extraction and sign/zero extension. Inputs: word, addr[1:0], size, signed. Output: 32-bit result.

## Test plan
- Fetch word at 0x0000_0010, ROM returns 0xDEADBEEF with hready_inst=1 → HSEL1 high in ADDR, hprot=0010, resp_valid 3 cycles after accept, rdata=0xDEADBEEF, err=0.
- Signed byte load at 0x1000_0003, RAM returns 0x80112233 → rdata=0xFFFFFF80. Unsigned half at 0x1000_0002 → 0x00008011.
- Byte store 0xA5 to 0x1000_0001 → hwrite=1, hsize=0, hwdata=0xA5A5A5A5, resp_err=0.
- Word load at 0x1000_0002 (misaligned) and store to 0x0000_0000 (ROM) → resp_err=1 one cycle after accept, HSEL1/HSEL2 never asserted.
- hready_data held low 20 cycles, TIMEOUT_CYCLES=16 → resp_err=1 at cycle 18 after ADDR. Separately: hresp_data=1 then hready_data=1 → err=1.
- Reset driven low during DATA → next edge: state IDLE, htrans=00, no resp_valid; next request completes normally.
